sram_banked_ctrl: RTL and testbench

SRAM_BANKED_CTRL -- requirements
Module: sram_banked_ctrl

---
 rtl/sram_banked_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_banked_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_ctrl.sv
// Banked SRAM controller: low-order bank interleave, per-bank idle sleep, 2-deep read response queue.
// Read data is visible one cycle after grant; grants stall when the response path is full or the bank sleeps.
module sram_banked_ctrl #(
  parameter int NUM_WORDS   = 2048,
  parameter int DATA_W      = 32,
  parameter int NUM_BANKS   = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int ADDR_W      = $clog2(NUM_WORDS),
  parameter int BS_W        = $clog2(NUM_BANKS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scan_en_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [DATA_W/8-1:0]  be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DATA_W-1:0]    rdata_o,
  input  logic                 rready_i,
  output logic [NUM_BANKS-1:0] bank_sleep_o
);
  localparam int ROWS   = NUM_WORDS / NUM_BANKS;
  localparam int NBE    = DATA_W / 8;
  localparam int BANK_W = (BS_W > 0) ? BS_W : 1;
  localparam int CNT_W  = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  logic [BANK_W-1:0]      bank_sel;
  logic [ADDR_W-BS_W-1:0] row_sel;
  logic [NUM_BANKS-1:0]   sleep_vec;
  logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]      inflight_data;
  logic [DATA_W-1:0]      fifo_q [2];
  logic                   rptr_q, wptr_q, inflight_q;
  logic [1:0]             cnt_q, occ;
  logic [BANK_W-1:0]      rd_bank_q;
  logic                   rd_gnt, pop, pop_fifo, push;

  if (BS_W > 0) begin : g_bs
    assign bank_sel = addr_i[BS_W-1:0];
  end else begin : g_nobs
    assign bank_sel = '0;
  end
  assign row_sel = addr_i[ADDR_W-1:BS_W];

  // Occupancy counts the queued entries plus the read whose data is still on the bank output.
  assign occ    = cnt_q + {1'b0, inflight_q};
  assign gnt_o  = rst_ni & req_i & ~scan_en_i & ~sleep_vec[bank_sel] & (we_i | (occ < 2'd2));
  assign rd_gnt = gnt_o & ~we_i;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] arr [ROWS];
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  idle_q;
    logic              sleep_q;
    logic              hit, en;

    assign hit = (bank_sel == BANK_W'(b));
    assign en  = gnt_o & hit;

    always_ff @(posedge clk_i) begin
      if (en) begin
        if (we_i) begin
          for (int k = 0; k < NBE; k++) begin
            if (be_i[k]) arr[row_sel][k*8 +: 8] <= wdata_i[k*8 +: 8];
          end
        end else begin
          rdata_q <= arr[row_sel];
        end
      end
    end

    // A request to a sleeping bank only wakes it; the counter restarts so it does not re-sleep at once.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        idle_q  <= '0;
        sleep_q <= 1'b0;
      end else if (!scan_en_i) begin
        if (sleep_q) begin
          if (req_i && hit) begin
            sleep_q <= 1'b0;
            idle_q  <= '0;
          end
        end else if (en) begin
          idle_q <= '0;
        end else if (idle_q == IDLE_MAX) begin
          sleep_q <= 1'b1;
        end else begin
          idle_q <= idle_q + CNT_W'(1);
        end
      end
    end

    assign bank_rdata[b] = rdata_q;
    assign sleep_vec[b]  = sleep_q;
  end

  assign inflight_data = bank_rdata[rd_bank_q];
  assign rvalid_o      = (cnt_q != 2'd0) | inflight_q;
  assign rdata_o       = (cnt_q != 2'd0) ? fifo_q[rptr_q] :
                         (inflight_q ? inflight_data : '0);
  assign pop           = rvalid_o & rready_i;
  assign pop_fifo      = pop & (cnt_q != 2'd0);
  assign push          = inflight_q & ~(pop & (cnt_q == 2'd0));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      inflight_q <= rd_gnt;
      if (rd_gnt) rd_bank_q <= bank_sel;
      if (push) begin
        fifo_q[wptr_q] <= inflight_data;
        wptr_q         <= ~wptr_q;
      end
      if (pop_fifo) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

  assign bank_sleep_o = sleep_vec;
endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Self-checking bench for sram_banked_ctrl: directed vector table, corner-case sequences,
// and random traffic against a queue/age based reference model.
module tb_sram_banked_ctrl;
  localparam int NW = 2048, DW = 32, NB = 4, IDLE = 16, AW = 11;

  logic          clk = 1'b0;
  logic          rst_n, scan, req, we, rready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [NB-1:0] bank_sleep;

  always #5 clk = ~clk;

  sram_banked_ctrl #(.NUM_WORDS(NW), .DATA_W(DW), .NUM_BANKS(NB), .IDLE_CYCLES(IDLE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .rready_i(rready), .bank_sleep_o(bank_sleep)
  );

  int n_chk = 0, n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: memory image, outstanding responses in order, cycles since each bank was last used.
  logic [DW-1:0] m_mem [NW];
  logic [DW-1:0] m_q [$];
  int            m_age [NB];

  logic          s_gnt, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [NB-1:0] s_sleep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s, input bit r, input bit w, input int a,
                       input logic [31:0] d, input logic [3:0] b, input bit rr);
    scan = s; req = r; we = w; addr = AW'(a); wdata = d; be = b; rready = rr;
  endtask

  task automatic tick();
    int            bk;
    bit            e_gnt;
    logic [NB-1:0] e_sleep;
    bit            waking;
    #4;
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata; s_sleep = bank_sleep;
    bk = int'(addr) % NB;
    for (int b = 0; b < NB; b++) e_sleep[b] = (m_age[b] > IDLE);
    e_gnt = rst_n && req && !scan && !e_sleep[bk] && (we || m_q.size() < 2);
    if (chk_en) begin
      check("model gnt", 32'(s_gnt), 32'(e_gnt));
      check("model rvalid", 32'(s_rvalid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("model rdata", s_rdata, m_q[0]);
      check("model sleep", 32'(s_sleep), 32'(e_sleep));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      for (int b = 0; b < NB; b++) m_age[b] = 0;
    end else begin
      if (m_q.size() > 0 && rready) void'(m_q.pop_front());
      if (e_gnt) begin
        if (we) begin
          for (int k = 0; k < 4; k++) if (be[k]) m_mem[addr][k*8 +: 8] = wdata[k*8 +: 8];
        end else begin
          m_q.push_back(m_mem[addr]);
        end
      end
      if (!scan) begin
        for (int b = 0; b < NB; b++) begin
          waking = e_sleep[b] && req && (bk == b);
          if (waking || (e_gnt && bk == b)) m_age[b] = 0;
          else if (m_age[b] < 1000) m_age[b]++;
        end
      end
    end
    #1;
  endtask

  typedef struct {
    bit          s, r, w;
    int          a;
    logic [31:0] d;
    logic [3:0]  b;
    bit          e_gnt, e_rvalid;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit hold;
    tbl[0]  = '{0, 1, 1, 2, 32'hCAFEF00D, 4'hF, 1, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 5, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0};
    tbl[2]  = '{0, 1, 0, 5, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF};
    tbl[4]  = '{0, 1, 1, 6, 32'h11223344, 4'hF, 1, 0, 32'h0};
    tbl[5]  = '{0, 1, 1, 6, 32'hAABBCCDD, 4'h5, 1, 0, 32'h0};
    tbl[6]  = '{0, 1, 0, 6, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[7]  = '{0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 32'h11BB33DD};
    tbl[8]  = '{1, 1, 1, 6, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0};
    tbl[9]  = '{1, 1, 1, 2, 32'h00000000, 4'hF, 0, 0, 32'h0};
    tbl[10] = '{0, 1, 0, 6, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[11] = '{0, 1, 0, 2, 32'h0,        4'h0, 1, 1, 32'h11BB33DD};
    tbl[12] = '{0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 32'hCAFEF00D};
    tbl[13] = '{0, 1, 1, 5, 32'hFFFFFFFF, 4'h0, 1, 0, 32'h0};
    tbl[14] = '{0, 1, 0, 5, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[15] = '{0, 0, 0, 0, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 4'h0, 1);
    @(posedge clk); #1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("reset gnt", 32'(s_gnt), 32'd0);
    check("reset rvalid", 32'(s_rvalid), 32'd0);
    check("reset rdata", s_rdata, 32'h0);
    check("reset sleep", 32'(s_sleep), 32'd0);

    // Directed vectors: write/read, byte enables, scan blocking, read right after write.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, 1);
      tick();
      check($sformatf("vec%0d gnt", i), 32'(s_gnt), 32'(tbl[i].e_gnt));
      check($sformatf("vec%0d rvalid", i), 32'(s_rvalid), 32'(tbl[i].e_rvalid));
      if (tbl[i].e_rvalid) check($sformatf("vec%0d rdata", i), s_rdata, tbl[i].e_rdata);
    end

    // Backpressure: three back-to-back reads with the consumer stalled.
    drive(0, 1, 0, 5, 32'h0, 4'h0, 0); tick();
    check("bp read1 gnt", 32'(s_gnt), 32'd1);
    drive(0, 1, 0, 6, 32'h0, 4'h0, 0); tick();
    check("bp read2 gnt", 32'(s_gnt), 32'd1);
    check("bp head", s_rdata, 32'hDEADBEEF);
    drive(0, 1, 0, 5, 32'h0, 4'h0, 0); tick();
    check("bp read3 stalled", 32'(s_gnt), 32'd0);
    tick();
    check("bp read3 still stalled", 32'(s_gnt), 32'd0);
    check("bp rdata stable", s_rdata, 32'hDEADBEEF);
    rready = 1'b1; tick();
    check("bp drain1 gnt", 32'(s_gnt), 32'd0);
    check("bp drain1 data", s_rdata, 32'hDEADBEEF);
    tick();
    check("bp read3 granted", 32'(s_gnt), 32'd1);
    check("bp drain2 data", s_rdata, 32'h11BB33DD);
    req = 1'b0; tick();
    check("bp drain3 data", s_rdata, 32'hDEADBEEF);
    tick();
    check("bp empty", 32'(s_rvalid), 32'd0);

    // Sleep and wake on bank 2.
    n = 0;
    while (!s_sleep[2] && n < 40) begin tick(); n++; end
    check("sleep bank2 entered", 32'(s_sleep[2]), 32'd1);
    drive(0, 1, 0, 2, 32'h0, 4'h0, 1); tick();
    check("wake first gnt", 32'(s_gnt), 32'd0);
    check("wake first sleep", 32'(s_sleep[2]), 32'd1);
    tick();
    check("wake second sleep", 32'(s_sleep[2]), 32'd0);
    check("wake second gnt", 32'(s_gnt), 32'd1);
    req = 1'b0; tick();
    check("wake rvalid", 32'(s_rvalid), 32'd1);
    check("wake rdata", s_rdata, 32'hCAFEF00D);

    // Reset while a read is in flight.
    drive(0, 1, 0, 2, 32'h0, 4'h0, 0); tick();
    check("rstmid read gnt", 32'(s_gnt), 32'd1);
    rst_n = 1'b0; tick();
    check("rstmid reset gnt", 32'(s_gnt), 32'd0);
    rst_n = 1'b1; drive(0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
    check("rstmid rvalid", 32'(s_rvalid), 32'd0);
    check("rstmid rdata", s_rdata, 32'h0);
    tick();
    check("rstmid rvalid later", 32'(s_rvalid), 32'd0);

    // Random traffic over a 32-word window, pre-initialised so every read is defined.
    for (int a = 0; a < 32; a++) begin
      drive(0, 1, 1, a, $urandom, 4'hF, 1);
      tick();
    end
    req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      hold = req && !s_gnt;
      rst_n  = ($urandom % 400) != 0;
      scan   = ($urandom % 100) < 5;
      rready = ($urandom % 100) < 70;
      if (!hold) begin
        req   = ($urandom % 100) < 60;
        we    = $urandom % 2;
        addr  = AW'(($urandom % 8) * 4 + (((i / 80) % 2) != 0 ? $urandom % 2 : $urandom % 4));
        wdata = $urandom;
        be    = 4'($urandom % 16);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
